// File: rtl/pid_ctrl_gen.sv
// -----------------------------------------------------------------------------
// pid_ctrl_gen
// Balance PID controller for the self-balancing platform. It takes pitch
// samples from the inertial interface and produces a saturated control word
// for the segway math / motor drive stage. It also produces a soft-start ramp.
//
// Datapath:
//   * pitch error saturated to ERR_W bits
//   * clamping integrator (INT_W bits) with a rail flag
//   * one capture stage for err/rate, then a registered P+I+D sum
//   * soft-start counter whose top SS_W bits form the ramp value
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   vld        new ptch/ptch_rt sample this cycle
//   ptch       signed pitch error (16 bit)
//   ptch_rt    signed pitch rate (16 bit)
//   pwr_up     0 holds the soft-start counter at zero
//   rider_off  clears the integrator
//   PID_cntrl  registered signed control word (OUT_W bits)
//   cntrl_vld  one-cycle strobe marking a PID_cntrl computed from a new sample
//   int_sat    integrator currently sits on a rail
//   ss_tmr     soft-start ramp value (SS_W bits)
//   ss_done    ss_tmr is all ones
// -----------------------------------------------------------------------------
module pid_ctrl_gen #(
    parameter int ERR_W    = 10,
    parameter int INT_W    = 18,
    parameter int OUT_W    = 12,
    parameter int P_COEFF  = 12,
    parameter int FAST_SIM = 1,
    parameter int SS_CNT_W = 27,
    parameter int SS_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vld,
    input  logic signed [15:0]      ptch,
    input  logic signed [15:0]      ptch_rt,
    input  logic                    pwr_up,
    input  logic                    rider_off,
    output logic [OUT_W-1:0]        PID_cntrl,
    output logic                    cntrl_vld,
    output logic                    int_sat,
    output logic [SS_W-1:0]         ss_tmr,
    output logic                    ss_done
);

    localparam int I_SH  = (FAST_SIM != 0) ? 1 : 6;
    localparam int I_W   = OUT_W + 3;
    localparam int P_W   = ERR_W + 5;
    localparam int D_W   = 10;
    localparam int SUM_W = OUT_W + 4;

    localparam logic signed [15:0] ERR_MAX = 16'(2**(ERR_W-1) - 1);
    localparam logic signed [15:0] ERR_MIN = 16'(-(2**(ERR_W-1)));

    localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

    localparam logic signed [I_W-1:0]   I_MAX   = {1'b0, {(I_W-1){1'b1}}};
    localparam logic signed [I_W-1:0]   I_MIN   = {1'b1, {(I_W-1){1'b0}}};

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    localparam logic signed [P_W-1:0]   P_K     = P_W'(P_COEFF);
    localparam logic [SS_CNT_W-1:0]     SS_INC  = (FAST_SIM != 0) ? SS_CNT_W'(256) : SS_CNT_W'(1);

    // State
    logic signed [INT_W-1:0] int_q,   int_d;
    logic                    sat_q,   sat_d;
    logic signed [ERR_W-1:0] err_q,   err_d;
    logic signed [15:0]      rt_q,    rt_d;
    logic                    vld_q,   vld_d;
    logic [OUT_W-1:0]        pid_q,   pid_d;
    logic                    cvld_q,  cvld_d;
    logic [SS_CNT_W-1:0]     ss_cnt_q, ss_cnt_d;

    // Combinational intermediates
    logic signed [ERR_W-1:0] err;
    logic signed [INT_W:0]   int_sum;
    logic signed [INT_W-1:0] int_shr;
    logic signed [I_W-1:0]   i_term;
    logic signed [P_W-1:0]   err_ext;
    logic signed [P_W-1:0]   p_term;
    logic signed [D_W-1:0]   d_term;
    logic signed [SUM_W-1:0] sum;
    logic                    unused_rt_bits;

    // Pitch error saturated to ERR_W bits.
    always_comb begin
        err = ptch[ERR_W-1:0];
        if (ptch > ERR_MAX) begin
            err = ERR_MAX[ERR_W-1:0];
        end else if (ptch < ERR_MIN) begin
            err = ERR_MIN[ERR_W-1:0];
        end
    end

    // Integrator: rider_off wins, otherwise accumulate with clamping on vld.
    // The sum is one bit wider so overflow shows as a mismatch of the top two
    // bits; the top bit then tells which rail to clamp to.
    always_comb begin
        int_sum = {int_q[INT_W-1], int_q} + {{(INT_W+1-ERR_W){err[ERR_W-1]}}, err};
        int_d   = int_q;
        if (rider_off) begin
            int_d = '0;
        end else if (vld) begin
            if (int_sum[INT_W] != int_sum[INT_W-1]) begin
                int_d = int_sum[INT_W] ? INT_MIN : INT_MAX;
            end else begin
                int_d = int_sum[INT_W-1:0];
            end
        end
        sat_d = (int_d == INT_MAX) || (int_d == INT_MIN);
    end

    // Stage-1 capture of the sample.
    always_comb begin
        err_d = vld ? err : err_q;
        rt_d  = vld ? ptch_rt : rt_q;
        vld_d = vld;
    end

    // I term: shifted integrator, saturated to I_W bits.
    assign int_shr = int_q >>> I_SH;

    generate
        if (INT_W > I_W) begin : g_isat
            always_comb begin
                i_term = int_shr[I_W-1:0];
                if (!((&int_shr[INT_W-1:I_W-1]) || !(|int_shr[INT_W-1:I_W-1]))) begin
                    i_term = int_shr[INT_W-1] ? I_MIN : I_MAX;
                end
            end
        end else if (INT_W == I_W) begin : g_ieq
            assign i_term = int_shr;
        end else begin : g_iext
            assign i_term = {{(I_W-INT_W){int_shr[INT_W-1]}}, int_shr};
        end
    endgenerate

    // P term: the product always fits in ERR_W+5 bits because the gain is < 32.
    assign err_ext = {{5{err_q[ERR_W-1]}}, err_q};
    assign p_term  = err_ext * P_K;

    // D term: ~(rt >>> 6). The shifted rate fits in 10 bits, so only the upper
    // ten rate bits matter and the complement stays within 10 bits.
    assign d_term         = ~rt_q[15:6];
    assign unused_rt_bits = ^rt_q[5:0];

    assign sum = {{(SUM_W-P_W){p_term[P_W-1]}}, p_term}
               + {{(SUM_W-I_W){i_term[I_W-1]}}, i_term}
               + {{(SUM_W-D_W){d_term[D_W-1]}}, d_term};

    // Output register recomputed every cycle; saturate the sum to OUT_W bits.
    always_comb begin
        pid_d = sum[OUT_W-1:0];
        if (!((&sum[SUM_W-1:OUT_W-1]) || !(|sum[SUM_W-1:OUT_W-1]))) begin
            pid_d = sum[SUM_W-1] ? OUT_MIN : OUT_MAX;
        end
        cvld_d = vld_q;
    end

    // Soft-start counter stops once bits [SS_CNT_W-1:8] are all ones, so it
    // can never wrap for either increment size.
    always_comb begin
        ss_cnt_d = ss_cnt_q;
        if (!pwr_up) begin
            ss_cnt_d = '0;
        end else if (!(&ss_cnt_q[SS_CNT_W-1:8])) begin
            ss_cnt_d = ss_cnt_q + SS_INC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_q    <= '0;
            sat_q    <= 1'b0;
            err_q    <= '0;
            rt_q     <= '0;
            vld_q    <= 1'b0;
            pid_q    <= '0;
            cvld_q   <= 1'b0;
            ss_cnt_q <= '0;
        end else begin
            int_q    <= int_d;
            sat_q    <= sat_d;
            err_q    <= err_d;
            rt_q     <= rt_d;
            vld_q    <= vld_d;
            pid_q    <= pid_d;
            cvld_q   <= cvld_d;
            ss_cnt_q <= ss_cnt_d;
        end
    end

    assign PID_cntrl = pid_q;
    assign cntrl_vld = cvld_q;
    assign int_sat   = sat_q;
    assign ss_tmr    = ss_cnt_q[SS_CNT_W-1 -: SS_W];
    assign ss_done   = &ss_tmr;

endmodule

// File: tb/tb_pid_ctrl_gen.sv
// -----------------------------------------------------------------------------
// tb_pid_ctrl_gen
// Directed self-checking bench for pid_ctrl_gen. A default instance covers the
// datapath and the start of the soft-start ramp; a second instance with a
// 20-bit soft-start counter reaches ss_done within a short run.
// -----------------------------------------------------------------------------
module tb_pid_ctrl_gen;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               vld;
    logic signed [15:0] ptch;
    logic signed [15:0] ptch_rt;
    logic               pwr_up;
    logic               rider_off;

    logic [11:0] PID_cntrl;
    logic        cntrl_vld;
    logic        int_sat;
    logic [7:0]  ss_tmr;
    logic        ss_done;

    logic [11:0] s_PID_cntrl;
    logic        s_cntrl_vld;
    logic        s_int_sat;
    logic [7:0]  s_ss_tmr;
    logic        s_ss_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pid_ctrl_gen u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld       (vld),
        .ptch      (ptch),
        .ptch_rt   (ptch_rt),
        .pwr_up    (pwr_up),
        .rider_off (rider_off),
        .PID_cntrl (PID_cntrl),
        .cntrl_vld (cntrl_vld),
        .int_sat   (int_sat),
        .ss_tmr    (ss_tmr),
        .ss_done   (ss_done)
    );

    pid_ctrl_gen #(.SS_CNT_W(20)) u_dut_ss (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld       (vld),
        .ptch      (ptch),
        .ptch_rt   (ptch_rt),
        .pwr_up    (pwr_up),
        .rider_off (rider_off),
        .PID_cntrl (s_PID_cntrl),
        .cntrl_vld (s_cntrl_vld),
        .int_sat   (s_int_sat),
        .ss_tmr    (s_ss_tmr),
        .ss_done   (s_ss_done)
    );

    // Reference arithmetic for the default parameter set.
    function automatic int sat_to(input int v, input int w);
        int lo;
        int hi;
        lo = -(1 <<< (w - 1));
        hi = (1 <<< (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int pid_model(input int e, input int integ, input int rt);
        int p;
        int i;
        int d;
        p = e * 12;
        i = sat_to(integ >>> 1, 15);
        d = -(rt >>> 6) - 1;
        return sat_to(p + i + d, 12);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vld = 1'b0; ptch = '0; ptch_rt = '0; pwr_up = 1'b0; rider_off = 1'b0;
        step(); step();
        n_vec++;
        if ({PID_cntrl, cntrl_vld, int_sat, ss_tmr, ss_done} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got pid=%h vld=%b sat=%b tmr=%h done=%b, want all zero",
                     PID_cntrl, cntrl_vld, int_sat, ss_tmr, ss_done);
        end
        n_vec++;
        if ({s_PID_cntrl, s_cntrl_vld, s_int_sat, s_ss_tmr, s_ss_done} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_outputs_ss: got pid=%h vld=%b sat=%b tmr=%h done=%b, want all zero",
                     s_PID_cntrl, s_cntrl_vld, s_int_sat, s_ss_tmr, s_ss_done);
        end
        rst_n = 1'b1;
        step();
        $display("txn reset released");
    endtask

    task automatic test_single_sample();
        vld = 1'b1; ptch = 16'h0010; ptch_rt = 16'h0000;
        step();
        vld = 1'b0;
        n_vec++;
        if (cntrl_vld !== 1'b0) begin
            n_err++; $display("FAIL single_vld_early: got %b want 0", cntrl_vld);
        end
        step();
        n_vec++;
        if (PID_cntrl !== 12'h0C7) begin
            n_err++; $display("FAIL single_pid: got %h want 0c7", PID_cntrl);
        end
        n_vec++;
        if (cntrl_vld !== 1'b1) begin
            n_err++; $display("FAIL single_vld: got %b want 1", cntrl_vld);
        end
        step();
        n_vec++;
        if (cntrl_vld !== 1'b0 || PID_cntrl !== 12'h0C7) begin
            n_err++; $display("FAIL single_after: got vld=%b pid=%h want vld=0 pid=0c7", cntrl_vld, PID_cntrl);
        end
        $display("txn single sample ptch=0010 pid=%h", PID_cntrl);
    endtask

    task automatic test_saturation();
        vld = 1'b1; ptch = 16'h7FFF; ptch_rt = 16'h0000;
        step();
        vld = 1'b0;
        step();
        n_vec++;
        if (PID_cntrl !== 12'h7FF) begin
            n_err++; $display("FAIL sat_pos: got %h want 7ff", PID_cntrl);
        end
        vld = 1'b1; rider_off = 1'b1; ptch = 16'h8000; ptch_rt = 16'h7FC0;
        step();
        vld = 1'b0; rider_off = 1'b0;
        step();
        n_vec++;
        if (PID_cntrl !== 12'h800) begin
            n_err++; $display("FAIL sat_neg: got %h want 800", PID_cntrl);
        end
        $display("txn saturation pid=%h", PID_cntrl);
    endtask

    task automatic test_int_clamp();
        // Integrator is zero here after the rider_off sample.
        ptch = 16'h01FF; ptch_rt = 16'h0000; vld = 1'b1;
        for (int i = 0; i < 256; i++) step();
        n_vec++;
        if (int_sat !== 1'b0) begin
            n_err++; $display("FAIL clamp_256: int_sat got %b want 0", int_sat);
        end
        step();
        n_vec++;
        if (int_sat !== 1'b1) begin
            n_err++; $display("FAIL clamp_257: int_sat got %b want 1", int_sat);
        end
        ptch = 16'hFE00;
        step();
        n_vec++;
        if (int_sat !== 1'b0) begin
            n_err++; $display("FAIL clamp_leave: int_sat got %b want 0", int_sat);
        end
        // 130559 - 255*512 = -1, readable through the output with err=0.
        for (int i = 0; i < 255; i++) step();
        ptch = 16'h0000;
        step();
        vld = 1'b0;
        step();
        n_vec++;
        if (PID_cntrl !== 12'hFFE) begin
            n_err++; $display("FAIL clamp_drain: got %h want ffe", PID_cntrl);
        end
        $display("txn integrator clamp drain pid=%h", PID_cntrl);
    endtask

    task automatic test_rider_priority();
        vld = 1'b1; ptch = 16'h0040; ptch_rt = 16'h0000;
        step();
        rider_off = 1'b1; ptch = 16'h0020;
        step();
        vld = 1'b0; rider_off = 1'b0;
        n_vec++;
        if (int_sat !== 1'b0) begin
            n_err++; $display("FAIL rider_sat: got %b want 0", int_sat);
        end
        step();
        n_vec++;
        if (PID_cntrl !== 12'h17F || cntrl_vld !== 1'b1) begin
            n_err++; $display("FAIL rider_pid: got pid=%h vld=%b want pid=17f vld=1", PID_cntrl, cntrl_vld);
        end
        $display("txn rider_off with vld pid=%h", PID_cntrl);
    endtask

    task automatic test_back_to_back();
        int integ_m;
        int exp_q[$];
        int e;
        int r;
        int exp_v;
        rider_off = 1'b1; vld = 1'b0;
        step();
        rider_off = 1'b0;
        integ_m = 0;
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                e = 30 - 10 * k;
                r = 300 * k - 1000;
                vld = 1'b1; ptch = 16'(e); ptch_rt = 16'(r);
                integ_m = integ_m + e;
                exp_q.push_back(pid_model(e, integ_m, r));
            end else begin
                vld = 1'b0;
            end
            step();
            if (k >= 1) begin
                exp_v = exp_q.pop_front();
                n_vec++;
                if (PID_cntrl !== 12'(exp_v) || cntrl_vld !== 1'b1) begin
                    n_err++;
                    $display("FAIL stream_%0d: got pid=%h vld=%b want pid=%h vld=1",
                             k - 1, PID_cntrl, cntrl_vld, 12'(exp_v));
                end
                $display("txn stream sample %0d pid=%h", k - 1, PID_cntrl);
            end
        end
        step();
        n_vec++;
        if (cntrl_vld !== 1'b0) begin
            n_err++; $display("FAIL stream_end: vld got %b want 0", cntrl_vld);
        end
        // rider_off pulse without vld: integrator 0, output follows one edge later.
        rider_off = 1'b1;
        step();
        rider_off = 1'b0;
        n_vec++;
        if (PID_cntrl !== 12'(pid_model(-40, -40, 1100))) begin
            n_err++; $display("FAIL rider_novld_hold: got %h want %h", PID_cntrl, 12'(pid_model(-40, -40, 1100)));
        end
        step();
        n_vec++;
        if (PID_cntrl !== 12'(pid_model(-40, 0, 1100)) || cntrl_vld !== 1'b0) begin
            n_err++;
            $display("FAIL rider_novld: got pid=%h vld=%b want pid=%h vld=0",
                     PID_cntrl, cntrl_vld, 12'(pid_model(-40, 0, 1100)));
        end
        $display("txn rider_off pulse pid=%h", PID_cntrl);
    endtask

    task automatic test_soft_start();
        rst_n = 1'b0; pwr_up = 1'b1; vld = 1'b0; rider_off = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 4200; k++) begin
            step();
            if (k == 2047 || k == 2048 || k == 4096) begin
                n_vec++;
                if (ss_tmr !== 8'(k / 2048)) begin
                    n_err++; $display("FAIL ss_tmr_at_%0d: got %h want %h", k, ss_tmr, 8'(k / 2048));
                end
            end
            if (k == 4079 || k == 4080 || k == 4200) begin
                n_vec++;
                if (s_ss_done !== (k >= 4080) || s_ss_tmr !== ((k >= 4080) ? 8'hFF : 8'hFE)) begin
                    n_err++;
                    $display("FAIL ss_done_at_%0d: got done=%b tmr=%h", k, s_ss_done, s_ss_tmr);
                end
            end
        end
        pwr_up = 1'b0;
        step();
        n_vec++;
        if (ss_tmr !== 8'h00 || s_ss_done !== 1'b0) begin
            n_err++; $display("FAIL ss_pwr_down: got tmr=%h done=%b want 00 0", ss_tmr, s_ss_done);
        end
        $display("txn soft start tmr=%h", ss_tmr);
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_saturation();
        test_int_clamp();
        test_rider_priority();
        test_back_to_back();
        test_soft_start();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pid_ctrl_gen.md
# pid_ctrl_gen

Parametrised second-generation balance PID controller for the self-balancing platform. It sits between the inertial interface, which supplies `ptch`, `ptch_rt` and `vld`, and the segway math / motor drive stage, which consumes `PID_cntrl`, `cntrl_vld` and `ss_tmr`. Compared with the first-generation PID it adds:
- generic error, integrator and output widths;
- a clamping (saturating) integrator with a status flag, replacing freeze-on-overflow;
- a registered output with a valid strobe;
- a parametrised soft-start counter with a done flag.

## Interface
Parameters:
- `ERR_W`, default 10: signed width of the saturated pitch error.
- `INT_W`, default 18: signed integrator width.
- `OUT_W`, default 12: signed width of `PID_cntrl`.
- `P_COEFF`, default 12: unsigned proportional gain (5-bit, at most 31).
- `FAST_SIM`, default 1: 1 gives I shift 1 and soft-start increment 256; 0 gives I shift 6 and increment 1.
- `SS_CNT_W`, default 27: soft-start counter width (at least 9).
- `SS_W`, default 8: `ss_tmr` width (the top `SS_W` bits of the counter).

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `vld`, input, 1: new `ptch`/`ptch_rt` sample this cycle.
- `ptch`, input, 16: signed pitch error.
- `ptch_rt`, input, 16: signed pitch rate.
- `pwr_up`, input, 1: 0 holds the soft-start counter at 0.
- `rider_off`, input, 1: clears the integrator.
- `PID_cntrl`, output, `OUT_W`: signed control word (registered).
- `cntrl_vld`, output, 1: one-cycle strobe marking a new `PID_cntrl`.
- `int_sat`, output, 1: integrator sits at +max or -min rail (registered).
- `ss_tmr`, output, `SS_W`: soft-start ramp value.
- `ss_done`, output, 1: `ss_tmr` is all ones.

## Operation
- **Error saturation:** `err` = `ptch` saturated to signed `ERR_W` bits. At the defaults, `err` lies in [-512, 511].
- **Integrator:** signed `INT_W` bits. Priority order:
  1. `rider_off` forces it to 0 (also clears `int_sat`).
  2. Otherwise, on `vld`, it takes the sum of the integrator and sign-extended `err`, clamped to [-2^(INT_W-1), 2^(INT_W-1)-1]. It never wraps.
  3. Otherwise it holds.
- **`int_sat`:** registered alongside the integrator. It is 1 exactly when the stored value equals either rail.
- **Stage-1 capture:** on `vld`, `err_q` ← `err`, `rt_q` ← `ptch_rt`, and `vld_q` ← `vld` every cycle.
- **P term:** `err_q` × `P_COEFF`, signed, `ERR_W`+5 bits.
- **I term:** integrator arithmetically shifted right by 1 (`FAST_SIM`=1) or 6 (`FAST_SIM`=0), then saturated to signed `OUT_W`+3 bits. At the defaults, I lies in [-16384, 16383].
- **D term:** bitwise complement of (`rt_q` arithmetically shifted right by 6), which equals -(`rt_q`>>>6) - 1.
- **Output sum:** P, I and D are sign-extended to `OUT_W`+4 bits and summed, then saturated to signed `OUT_W`. At the defaults, `PID_cntrl` lies in [0x800, 0x7FF].
- **Soft start:** a `SS_CNT_W`-bit counter.
  - `pwr_up`=0 clears it.
  - Otherwise it adds the increment every cycle while bits [`SS_CNT_W`-1:8] are not all ones, then holds. It never wraps.
  - `ss_tmr` = counter[`SS_CNT_W`-1 : `SS_CNT_W`-`SS_W`].
  - `ss_done` = `ss_tmr` is all ones (combinational from the counter).

## Timing
- **Reset values:** integrator, `err_q`, `rt_q`, `vld_q`, `PID_cntrl`, `cntrl_vld`, `int_sat` and the counter are all 0. Consequently `ss_tmr`=0 and `ss_done`=0.
- **Latency:** for `vld` high in cycle N, the integrator and `err_q`/`rt_q` update at edge N. At edge N+1, `PID_cntrl` is registered (using the updated integrator) and `cntrl_vld` is set. `cntrl_vld` stays high for one cycle per `vld`.
- **Throughput:** back-to-back `vld` every cycle is supported, with one `PID_cntrl` per cycle and `cntrl_vld` held continuously high.
- **Between samples:** `PID_cntrl` is recomputed every cycle from `err_q`, `rt_q` and the current integrator. Therefore a `rider_off` pulse without `vld` changes `PID_cntrl` one cycle later with `cntrl_vld`=0.
- **`rider_off` and `vld` in the same cycle:** the integrator becomes 0, `err_q` is still captured, and the output one edge later uses I=0.
- **Clamp boundary:** an addition landing exactly on a rail sets `int_sat`. A subsequent opposite-sign `err` leaves the rail and clears `int_sat` at that same edge.
- **Soft-start rate:** with `FAST_SIM`=1, `ss_tmr` increments every 2048 cycles and `ss_done` rises 522240 cycles after `pwr_up` rises. `pwr_up` falling clears the counter at the next edge.

## Test plan
- **Reset then single sample:** reset, then one `vld` with `ptch`=0x0010, `ptch_rt`=0 → integrator=16; two edges later `PID_cntrl`=0x0C7 (192+8-1) and `cntrl_vld` is high for exactly one cycle.
- **Error and output saturation:** `ptch`=0x7FFF, `ptch_rt`=0, one `vld` → `err`=511, P=6132, `PID_cntrl`=0x7FF. Then `ptch`=0x8000 and `ptch_rt`=0x7FC0 with `rider_off` → `PID_cntrl`=0x800.
- **Integrator clamp:** 256 consecutive `vld` with `ptch`=0x01FF → integrator=130816, `int_sat`=0; the 257th → integrator=131071, `int_sat`=1; next `vld` with `ptch`=0xFE00 → 130559, `int_sat`=0.
- **`rider_off` priority:** `rider_off`=1 concurrent with `vld` while the integrator is nonzero → integrator 0 at that edge, `int_sat`=0, and the output reflects I=0.
- **Soft start:** `pwr_up`=1 from reset → `ss_tmr`=1 at cycle 2048 and `ss_done`=1 at cycle 522240, both held thereafter (no wrap). `pwr_up`=0 mid-ramp → `ss_tmr`=0 at the next edge.
- **Streaming:** 8 back-to-back `vld` with ramping `ptch` → 8 consecutive `cntrl_vld` cycles. Each `PID_cntrl` matches a reference model one edge after its sample's integrator update.
